// File: rtl/product_accumulator.sv
// Burst accumulator for unsigned 8-bit products: IDLE -> ACCUM -> DONE with valid/ready on both sides.
// Optional macro PRODUCT_ACCUMULATOR_SAT_EN: saturate at 2^ACC_W-1 on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    // Handshake: a beat (or result) moves on a rising edge where valid and ready are both high;
    // in_ready is high only in ACCUM and out_valid only in DONE, both decoded from the state flop.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    // One extra bit captures the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_p};
    assign carry   = sum_ext[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_next;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator (ACC_W=9 so overflow is easy to reach).
module tb_product_accumulator;

    localparam int ACC_W = 9;
    localparam int LEN_W = 4;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    int total = 0;
    int bad   = 0;

    int prod_q[$];
    int gap_q[$];
    logic [ACC_W:0] exp_q[$];

    product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the whole burst summed in plain integers, then clipped or wrapped.
    function automatic logic [ACC_W:0] model_result();
        int full;
        logic [ACC_W-1:0] s;
        full = 0;
        foreach (prod_q[i]) full += prod_q[i];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        s = (full > MAXV) ? ACC_W'(MAXV) : ACC_W'(full);
`else
        s = ACC_W'(full % (MAXV + 1));
`endif
        return {(full > MAXV) ? 1'b1 : 1'b0, s};
    endfunction

    task automatic run_burst(input int bp, input bit poke);
        int n;
        int guard;
        logic [ACC_W:0] e;
        n = prod_q.size();
        exp_q.push_back(model_result());
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                in_valid = 1'b0;
                in_p     = 8'($urandom);
                if (poke) begin
                    start = 1'b1;
                    len   = LEN_W'($urandom);
                end
                step();
                start = 1'b0;
                check("gap_out_valid", out_valid, 0);
            end
            guard = 0;
            while (!in_ready && guard < 20) begin
                step();
                guard++;
            end
            check("beat_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_p     = 8'(prod_q[i]);
            step();
            in_valid = 1'b0;
        end
        e = exp_q.pop_front();
        check("done_out_valid", out_valid, 1);
        check("done_in_ready", in_ready, 0);
        check("done_sum", out_sum, e[ACC_W-1:0]);
        check("done_ovf", out_ovf, e[ACC_W]);
        for (int b = 0; b < bp; b++) begin
            out_ready = 1'b0;
            if (poke) begin
                start = 1'b1;
                len   = LEN_W'($urandom);
            end
            step();
            start = 1'b0;
            check("hold_out_valid", out_valid, 1);
            check("hold_sum", out_sum, e[ACC_W-1:0]);
            check("hold_ovf", out_ovf, e[ACC_W]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        prod_q.delete();
        gap_q.delete();
    endtask

    task automatic load(input int p, input int g);
        prod_q.push_back(p);
        gap_q.push_back(g);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_p = '0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", out_sum, 0);
        check("rst_ovf", out_ovf, 0);
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();

        // basic burst
        load(15, 0); load(225, 0); load(36, 0);
        run_burst(0, 1'b0);

        // gaps and backpressure
        load(10, 0); load(20, 2);
        run_burst(3, 1'b0);

        // zero-length burst
        run_burst(2, 1'b0);

        // overflow: 550 wraps to 38 or clips to 511
        load(225, 0); load(225, 0); load(100, 0);
        run_burst(1, 1'b0);

        // start while busy
        load(50, 1); load(60, 2); load(70, 1);
        run_burst(2, 1'b1);

        // reset mid-burst after 2 of 5 beats
        start = 1'b1; len = LEN_W'(5);
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_p = 8'(100 + i);
            step();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", out_sum, 0);
        check("midrst_ovf", out_ovf, 0);
        step();
        @(negedge clk) rst_n = 1'b1;
        load(7, 0);
        run_burst(0, 1'b0);

        // randomized bursts
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) begin
                load($urandom_range(0, 15) * $urandom_range(0, 15), $urandom_range(0, 2));
            end
            run_burst($urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator and result width (legal range 9..32).
REQ-002 SHALL have parameter LEN_W, default 4, width of the burst-length field (maximum burst 2^LEN_W-1 products).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W  number of products in the burst; latched when start is accepted.
REQ-007 SHALL have port in_valid  input  1  upstream 8-bit product present on in_p.
REQ-008 SHALL have port in_ready  output  1  block accepts in_p this cycle.
REQ-009 SHALL have port in_p  input  8  unsigned product from the 4x4 multiplier stage.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_sum  output  ACC_W  accumulated sum of the burst.
REQ-013 SHALL have port out_ovf  output  1  sticky flag: the sum exceeded 2^ACC_W-1 during the burst.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, ACCUM and DONE.
REQ-016 SHALL, in IDLE with start=1 and len>0: clear the accumulator and out_ovf, load the counter with len, and enter ACCUM.
REQ-017 SHALL, in IDLE with start=1 and len=0: clear the accumulator and out_ovf and enter DONE directly, so out_valid=1 with out_sum=0 on the next cycle.
REQ-018 SHALL ignore start in ACCUM and DONE; no latching and no restart.
REQ-019 SHALL drive in_ready=1 only in ACCUM; a beat transfers when in_valid and in_ready are both high in the same cycle.
REQ-020 SHALL, on each transfer, add the zero-extended in_p to the accumulator and decrement the counter by 1.
REQ-021 SHALL, on the transfer with counter=1, enter DONE so that out_valid rises on the cycle after the last beat (latency 1).
REQ-022 SHALL hold the accumulator and counter unchanged in ACCUM cycles with in_valid=0.
REQ-023 SHALL drive out_valid=1 only in DONE and hold out_sum and out_ovf stable until out_ready=1.
REQ-024 SHALL return to IDLE on the cycle after out_valid and out_ready are both high; a start in that following IDLE cycle is accepted.
REQ-025 SHALL set out_ovf when an addition carries out of bit ACC_W-1; the flag stays set until the next accepted start.
REQ-026 SHALL drive out_sum continuously from the accumulator register with no combinational path from in_p.

Reset
REQ-027 SHALL, while rst_n=0 and regardless of clk, force the following: state=IDLE, accumulator=0, counter=0, out_valid=0, in_ready=0, out_ovf=0, busy=0.
REQ-028 SHALL abort an in-progress burst on reset without producing a result, discarding partial sums.
REQ-029 SHALL resume clocked operation on the first rising edge of clk after rst_n deasserts.

Configuration
REQ-030 SHALL provide the macro PRODUCT_ACCUMULATOR_SAT_EN.
- When defined: on overflow the accumulator saturates at 2^ACC_W-1, holds there for the rest of the burst, and out_ovf is set.
- When undefined: the accumulator wraps modulo 2^ACC_W, and out_ovf is still set.

Verification
REQ-031 SHALL cover a basic burst: start with len=3; products 15, 225 and 36, each with in_valid=1 in a consecutive cycle -> out_valid=1 one cycle after the third beat, out_sum=276, out_ovf=0.
REQ-032 SHALL cover backpressure and gaps: len=2; in_valid toggles 1,0,0,1 with in_p=10,x,x,20; out_ready held low for 3 cycles -> out_sum=30 held stable; IDLE one cycle after out_ready=1.
REQ-033 SHALL cover a zero-length burst: start with len=0 -> out_valid=1 next cycle with out_sum=0 and in_ready never high.
REQ-034 SHALL cover overflow with ACC_W=9: len=3 with products 225, 225 and 100 -> with PRODUCT_ACCUMULATOR_SAT_EN, out_sum=511 and out_ovf=1; without it, out_sum=38 and out_ovf=1.
REQ-035 SHALL cover reset mid-burst: assert rst_n=0 after 2 of 5 beats -> all outputs return to reset values immediately; a new burst with len=1 and product 7 then yields out_sum=7.
REQ-036 SHALL cover start while busy: pulse start during ACCUM and during DONE -> no effect on counter, sum or state.
